// File: rtl/k_nearest_selector.sv
// K-nearest selector: keeps the K smallest (distance, type) pairs of a stream
// sorted ascending, then majority-votes over them with nearest-rank tie-break.
module k_nearest_selector #(
    parameter int K = 3,
    parameter int T = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_distance,
    input  logic [W-1:0] in_type,
    input  logic         in_last,
    output logic         result_valid,
    output logic [W-1:0] result_type,
    output logic [W-1:0] kth_distance,
    output logic         busy,
    output logic         err_type
);

    localparam int CW = $clog2(K + 1);
    localparam int TW = $clog2(T);

    typedef enum logic [1:0] {IDLE, COLLECT, VOTE, DONE} state_t;

    state_t         state_q, state_d;
    logic           vld_q  [K];
    logic           vld_d  [K];
    logic [W-1:0]   dist_q [K];
    logic [W-1:0]   dist_d [K];
    logic [TW-1:0]  typ_q  [K];
    logic [TW-1:0]  typ_d  [K];
    logic [TW-1:0]  cand_q, cand_d;
    logic [TW-1:0]  best_type_q, best_type_d;
    logic [CW-1:0]  best_cnt_q, best_cnt_d;
    logic [CW-1:0]  best_rank_q, best_rank_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_type_q, res_type_d;
    logic           err_q, err_d;

    logic           accept, type_ok, ins, vote_last, win;
    logic           gt      [K];
    logic           prev_gt [K];
    logic [CW-1:0]  cnt, rank, w_cnt;
    logic [TW-1:0]  w_type;

    assign accept    = in_valid && in_ready;
    assign type_ok   = in_type < W'(T);
    assign vote_last = cand_q == TW'(T - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (accept && in_last) state_d = VOTE;
                VOTE:    if (vote_last) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state_q == COLLECT) && !start;
        busy         = (state_q == COLLECT) || (state_q == VOTE);
        result_valid = res_valid_q;
        result_type  = res_type_q;
        err_type     = err_q;
        kth_distance = vld_q[K-1] ? dist_q[K-1] : '1;
    end

    // Invalid entries count as "further" so the insertion point is the first
    // entry that is empty or strictly further than the new sample.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            gt[i]      = !vld_q[i] || (dist_q[i] > in_distance);
            prev_gt[i] = 1'b0;
        end
        for (int i = 1; i < K; i++) begin
            prev_gt[i] = gt[i-1];
        end
        ins = type_ok && (!vld_q[K-1] || (in_distance < dist_q[K-1]));
    end

    always_comb begin
        cnt  = '0;
        rank = CW'(K);
        for (int i = K - 1; i >= 0; i--) begin
            if (vld_q[i] && (typ_q[i] == cand_q)) begin
                cnt  = cnt + CW'(1);
                rank = CW'(i);
            end
        end
        win = (cnt != '0) &&
              ((cnt > best_cnt_q) ||
               ((cnt == best_cnt_q) && (rank < best_rank_q)));
        w_type = win ? cand_q : best_type_q;
        w_cnt  = win ? cnt : best_cnt_q;
    end

    always_comb begin
        vld_d       = vld_q;
        dist_d      = dist_q;
        typ_d       = typ_q;
        cand_d      = cand_q;
        best_type_d = best_type_q;
        best_cnt_d  = best_cnt_q;
        best_rank_d = best_rank_q;
        res_valid_d = res_valid_q;
        res_type_d  = res_type_q;
        err_d       = err_q;
        if (start) begin
            for (int i = 0; i < K; i++) vld_d[i] = 1'b0;
            err_d       = 1'b0;
            res_valid_d = 1'b0;
            res_type_d  = '0;
        end else if (accept) begin
            if (!type_ok) begin
                err_d = 1'b1;
            end else if (ins) begin
                for (int i = 1; i < K; i++) begin
                    if (gt[i] && prev_gt[i]) begin
                        vld_d[i]  = vld_q[i-1];
                        dist_d[i] = dist_q[i-1];
                        typ_d[i]  = typ_q[i-1];
                    end
                end
                for (int i = 0; i < K; i++) begin
                    if (gt[i] && !prev_gt[i]) begin
                        vld_d[i]  = 1'b1;
                        dist_d[i] = in_distance;
                        typ_d[i]  = in_type[TW-1:0];
                    end
                end
            end
            if (in_last) begin
                cand_d      = '0;
                best_type_d = '0;
                best_cnt_d  = '0;
                best_rank_d = '1;
            end
        end else if (state_q == VOTE) begin
            cand_d      = cand_q + TW'(1);
            best_type_d = w_type;
            best_cnt_d  = w_cnt;
            best_rank_d = win ? rank : best_rank_q;
            if (vote_last) begin
                res_valid_d = 1'b1;
                res_type_d  = (w_cnt == '0) ? '1 : W'(w_type);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                vld_q[i]  <= 1'b0;
                dist_q[i] <= '0;
                typ_q[i]  <= '0;
            end
            cand_q      <= '0;
            best_type_q <= '0;
            best_cnt_q  <= '0;
            best_rank_q <= '0;
            res_valid_q <= 1'b0;
            res_type_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            dist_q      <= dist_d;
            typ_q       <= typ_d;
            cand_q      <= cand_d;
            best_type_q <= best_type_d;
            best_cnt_q  <= best_cnt_d;
            best_rank_q <= best_rank_d;
            res_valid_q <= res_valid_d;
            res_type_q  <= res_type_d;
            err_q       <= err_d;
        end
    end

endmodule
